cache_nway_lru: RTL
===================

Name: cache_nway_lru

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
- Sits between CPU and main memory using the existing CPU/memory handshake; generalises sets, ways and block words.
- Adds a full-cache flush command and saturating hit/miss performance counters.

Parameters:
ADDRESS_WIDTH, 8, word address width
DATA_WIDTH, 32, CPU word width
WORDS_PER_BLOCK, 4, words per line (power of 2, >=2); BLOCK_SIZE = DATA_WIDTH*WORDS_PER_BLOCK
NUM_SETS, 8, sets (power of 2); INDEX_WIDTH = log2(NUM_SETS)
NUM_WAYS, 4, ways per set (power of 2, >=2)
COUNTER_WIDTH, 16, width of hit/miss counters

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
addr  in  ADDRESS_WIDTH  word address {tag,index,offset}
read  in  1  read request, held until done
write  in  1  write request, held until done (read has priority if both high)
w_data  in  DATA_WIDTH  write word
flush  in  1  flush request, level, held until flush_done
done  out  1  one-cycle pulse, read/write complete
r_data  out  DATA_WIDTH  read word, valid with done, held until next read completes
flush_done  out  1  one-cycle pulse, flush complete
cache_req  out  1  memory request, held until mem_valid
cache_write  out  1  1 = writeback, 0 = refill
cache_addr  out  ADDRESS_WIDTH  line address, offset bits zero
cache_wdata  out  BLOCK_SIZE  writeback line
mem_valid  in  1  one-cycle memory completion pulse
mem_data  in  BLOCK_SIZE  refill line, valid with mem_valid
hit_count  out  COUNTER_WIDTH  saturating lookup-hit count
miss_count  out  COUNTER_WIDTH  saturating lookup-miss count

Behaviour:
- Reset (rst high at clk edge): state IDLE; all valid/dirty = 0; age[s][w] = w; done, flush_done, cache_req, cache_write, counters = 0; r_data, cache_addr, cache_wdata = 0. Reset mid-operation aborts immediately; no partial line written; cache_req drops next cycle.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, FLUSH_SCAN, FLUSH_WB.
- IDLE: read|write -> LOOKUP (request wins over flush); else flush -> FLUSH_SCAN with set/way pointer = 0.
- LOOKUP (one cycle): tag compare across all ways. Hit: read latches word, write merges word and sets dirty; LRU update; hit_count+1; -> RESPOND. Miss: miss_count+1; choose victim = lowest-index invalid way, else way with age NUM_WAYS-1; victim dirty -> WRITEBACK (cache_req=1, cache_write=1, cache_addr={victim tag,index,0}, cache_wdata=victim line) else REFILL (cache_req=1, cache_write=0, cache_addr={tag,index,0}).
- WRITEBACK: wait mem_valid; then issue refill request same cycle transition -> REFILL.
- REFILL: on mem_valid install mem_data, tag, valid=1, dirty=write; write merges w_data at offset; read takes word from mem_data; LRU update; cache_req=0; -> RESPOND.
- RESPOND: done=1 for exactly this cycle; -> IDLE. Hit latency: request seen in IDLE cycle T, done at T+2.
- LRU: accessed way age -> 0; ways with age < accessed old age increment; ages stay a permutation of 0..NUM_WAYS-1.
- Counters saturate at all-ones; no wrap.
- FLUSH_SCAN: one line per cycle, order set-major then way; valid&dirty -> FLUSH_WB (writeback request as above); else advance. After last line: flush_done=1 one cycle -> IDLE.
- FLUSH_WB: on mem_valid clear dirty (valid kept, LRU unchanged), cache_req=0, advance -> FLUSH_SCAN.
- mem_valid outside WRITEBACK/REFILL/FLUSH_WB is ignored.

Test Plan:
- Reset, read addr 0x04 -> miss, cache_req=1, cache_write=0, cache_addr=0x04; mem_valid with mem_data={32'h3,32'h2,32'h1,32'h0} -> done, r_data=0x0; read 0x05 -> done at T+2, r_data=0x1, hit_count=1, miss_count=1.
- Read 0x04,0x24,0x44,0x64 (fill set 1), read 0x04 again, read 0x84 -> refill with cache_addr=0x84 replaces the 0x24 way; subsequent read 0x24 misses.
- Write 0x25 w_data=0xDEADBEEF, then evict that way -> cache_req=1, cache_write=1, cache_addr=0x24, cache_wdata[63:32]=0xDEADBEEF, followed by refill request.
- Two dirty lines (set 1, set 5), flush high -> exactly two writebacks, set 1 first; flush_done single pulse; reread both -> hits, no memory traffic.
- rst asserted during REFILL with mem_valid low -> next cycle cache_req=0, counters=0; read of same address misses.
- mem_valid delayed 6 cycles on a miss -> cache_req held high throughout, done stays 0 until RESPOND.

Source files
------------

// File: rtl/cache_nway_lru.sv
// N-way set-associative write-back/write-allocate cache with true-LRU replacement,
// full-cache flush and saturating hit/miss counters.
module cache_nway_lru #(
    parameter int ADDRESS_WIDTH   = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 8,
    parameter int NUM_WAYS        = 4,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [ADDRESS_WIDTH-1:0]                addr,
    input  logic                                    read,
    input  logic                                    write,
    input  logic [DATA_WIDTH-1:0]                   w_data,
    input  logic                                    flush,
    output logic                                    done,
    output logic [DATA_WIDTH-1:0]                   r_data,
    output logic                                    flush_done,
    output logic                                    cache_req,
    output logic                                    cache_write,
    output logic [ADDRESS_WIDTH-1:0]                cache_addr,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0]   cache_wdata,
    input  logic                                    mem_valid,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0]   mem_data,
    output logic [COUNTER_WIDTH-1:0]                hit_count,
    output logic [COUNTER_WIDTH-1:0]                miss_count
);

    localparam int BLOCK_SIZE   = DATA_WIDTH * WORDS_PER_BLOCK;
    localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_WIDTH  = $clog2(NUM_SETS);
    localparam int WAY_WIDTH    = $clog2(NUM_WAYS);
    localparam int TAG_WIDTH    = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int PTR_WIDTH    = INDEX_WIDTH + WAY_WIDTH + 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOOKUP     = 3'd1;
    localparam logic [2:0] S_WRITEBACK  = 3'd2;
    localparam logic [2:0] S_REFILL     = 3'd3;
    localparam logic [2:0] S_RESPOND    = 3'd4;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd5;
    localparam logic [2:0] S_FLUSH_WB   = 3'd6;

    logic [2:0]                 state_q, state_d;
    logic [NUM_WAYS-1:0]        valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]        valid_d [NUM_SETS];
    logic [NUM_WAYS-1:0]        dirty_q [NUM_SETS];
    logic [NUM_WAYS-1:0]        dirty_d [NUM_SETS];
    logic [TAG_WIDTH-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_WIDTH-1:0]       tag_d   [NUM_SETS][NUM_WAYS];
    logic [BLOCK_SIZE-1:0]      data_q  [NUM_SETS][NUM_WAYS];
    logic [BLOCK_SIZE-1:0]      data_d  [NUM_SETS][NUM_WAYS];
    logic [WAY_WIDTH-1:0]       age_q   [NUM_SETS][NUM_WAYS];
    logic [WAY_WIDTH-1:0]       age_d   [NUM_SETS][NUM_WAYS];

    logic [DATA_WIDTH-1:0]      r_data_q, r_data_d;
    logic                       cache_req_q, cache_req_d;
    logic                       cache_write_q, cache_write_d;
    logic [ADDRESS_WIDTH-1:0]   cache_addr_q, cache_addr_d;
    logic [BLOCK_SIZE-1:0]      cache_wdata_q, cache_wdata_d;
    logic [COUNTER_WIDTH-1:0]   hit_count_q, hit_count_d;
    logic [COUNTER_WIDTH-1:0]   miss_count_q, miss_count_d;
    logic [WAY_WIDTH-1:0]       victim_q, victim_d;
    logic [PTR_WIDTH-1:0]       fptr_q, fptr_d;

    logic [TAG_WIDTH-1:0]       req_tag;
    logic [INDEX_WIDTH-1:0]     req_index;
    logic [OFFSET_WIDTH-1:0]    req_off;
    logic                       op_write;
    logic [INDEX_WIDTH-1:0]     flush_set;
    logic [WAY_WIDTH-1:0]       flush_way;
    logic                       hit;
    logic [WAY_WIDTH-1:0]       hit_way;
    logic                       has_invalid;
    logic [WAY_WIDTH-1:0]       invalid_way;
    logic [WAY_WIDTH-1:0]       lru_way;
    logic [WAY_WIDTH-1:0]       victim_way;
    logic                       touch_en;
    logic [WAY_WIDTH-1:0]       touch_way;
    logic [WAY_WIDTH-1:0]       touch_age;
    logic [BLOCK_SIZE-1:0]      refill_line;

    assign req_tag   = addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign req_index = addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off   = addr[OFFSET_WIDTH-1:0];
    assign op_write  = write & ~read;
    assign flush_set = fptr_q[WAY_WIDTH +: INDEX_WIDTH];
    assign flush_way = fptr_q[WAY_WIDTH-1:0];

    assign done        = (state_q == S_RESPOND);
    assign flush_done  = (state_q == S_FLUSH_SCAN) && fptr_q[PTR_WIDTH-1];
    assign r_data      = r_data_q;
    assign cache_req   = cache_req_q;
    assign cache_write = cache_write_q;
    assign cache_addr  = cache_addr_q;
    assign cache_wdata = cache_wdata_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    function automatic logic [DATA_WIDTH-1:0] get_word(input logic [BLOCK_SIZE-1:0] line,
                                                        input logic [OFFSET_WIDTH-1:0] off);
        return line[off*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [BLOCK_SIZE-1:0] put_word(input logic [BLOCK_SIZE-1:0] line,
                                                        input logic [OFFSET_WIDTH-1:0] off,
                                                        input logic [DATA_WIDTH-1:0] word);
        logic [BLOCK_SIZE-1:0] merged;
        merged = line;
        merged[off*DATA_WIDTH +: DATA_WIDTH] = word;
        return merged;
    endfunction

    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        invalid_way = '0;
        lru_way     = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[req_index][w] && tag_q[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_WIDTH'(w);
            end
            if (!has_invalid && !valid_q[req_index][w]) begin
                has_invalid = 1'b1;
                invalid_way = WAY_WIDTH'(w);
            end
            if (age_q[req_index][w] == WAY_WIDTH'(NUM_WAYS - 1)) begin
                lru_way = WAY_WIDTH'(w);
            end
        end
        victim_way = has_invalid ? invalid_way : lru_way;
    end

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        tag_d         = tag_q;
        data_d        = data_q;
        age_d         = age_q;
        r_data_d      = r_data_q;
        cache_req_d   = cache_req_q;
        cache_write_d = cache_write_q;
        cache_addr_d  = cache_addr_q;
        cache_wdata_d = cache_wdata_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        victim_d      = victim_q;
        fptr_d        = fptr_q;
        touch_en      = 1'b0;
        touch_way     = '0;
        refill_line   = mem_data;

        case (state_q)
            S_IDLE: begin
                if (read || write) begin
                    state_d = S_LOOKUP;
                end else if (flush) begin
                    state_d = S_FLUSH_SCAN;
                    fptr_d  = '0;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    touch_en  = 1'b1;
                    touch_way = hit_way;
                    if (op_write) begin
                        data_d[req_index][hit_way]  = put_word(data_q[req_index][hit_way], req_off, w_data);
                        dirty_d[req_index][hit_way] = 1'b1;
                    end else begin
                        r_data_d = get_word(data_q[req_index][hit_way], req_off);
                    end
                    hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + 1'b1;
                    state_d     = S_RESPOND;
                end else begin
                    miss_count_d = (&miss_count_q) ? miss_count_q : miss_count_q + 1'b1;
                    victim_d     = victim_way;
                    cache_req_d  = 1'b1;
                    if (valid_q[req_index][victim_way] && dirty_q[req_index][victim_way]) begin
                        cache_write_d = 1'b1;
                        cache_addr_d  = {tag_q[req_index][victim_way], req_index, {OFFSET_WIDTH{1'b0}}};
                        cache_wdata_d = data_q[req_index][victim_way];
                        state_d       = S_WRITEBACK;
                    end else begin
                        cache_write_d = 1'b0;
                        cache_addr_d  = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
                        state_d       = S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                // Refill request follows the writeback ack with cache_req left high.
                if (mem_valid) begin
                    cache_write_d = 1'b0;
                    cache_addr_d  = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
                    state_d       = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_valid) begin
                    if (op_write) begin
                        refill_line = put_word(mem_data, req_off, w_data);
                    end else begin
                        r_data_d = get_word(mem_data, req_off);
                    end
                    data_d[req_index][victim_q]  = refill_line;
                    tag_d[req_index][victim_q]   = req_tag;
                    valid_d[req_index][victim_q] = 1'b1;
                    dirty_d[req_index][victim_q] = op_write;
                    touch_en    = 1'b1;
                    touch_way   = victim_q;
                    cache_req_d = 1'b0;
                    state_d     = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            S_FLUSH_SCAN: begin
                if (fptr_q[PTR_WIDTH-1]) begin
                    state_d = S_IDLE;
                end else if (valid_q[flush_set][flush_way] && dirty_q[flush_set][flush_way]) begin
                    cache_req_d   = 1'b1;
                    cache_write_d = 1'b1;
                    cache_addr_d  = {tag_q[flush_set][flush_way], flush_set, {OFFSET_WIDTH{1'b0}}};
                    cache_wdata_d = data_q[flush_set][flush_way];
                    state_d       = S_FLUSH_WB;
                end else begin
                    fptr_d = fptr_q + 1'b1;
                end
            end
            S_FLUSH_WB: begin
                if (mem_valid) begin
                    dirty_d[flush_set][flush_way] = 1'b0;
                    cache_req_d = 1'b0;
                    fptr_d      = fptr_q + 1'b1;
                    state_d     = S_FLUSH_SCAN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        touch_age = age_q[req_index][touch_way];
        if (touch_en) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (WAY_WIDTH'(w) == touch_way) begin
                    age_d[req_index][w] = '0;
                end else if (age_q[req_index][w] < touch_age) begin
                    age_d[req_index][w] = age_q[req_index][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            r_data_q      <= '0;
            cache_req_q   <= 1'b0;
            cache_write_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_wdata_q <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            victim_q      <= '0;
            fptr_q        <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= WAY_WIDTH'(w);
                end
            end
        end else begin
            state_q       <= state_d;
            r_data_q      <= r_data_d;
            cache_req_q   <= cache_req_d;
            cache_write_q <= cache_write_d;
            cache_addr_q  <= cache_addr_d;
            cache_wdata_q <= cache_wdata_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            victim_q      <= victim_d;
            fptr_q        <= fptr_d;
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            age_q         <= age_d;
        end
    end

    // Line storage is not cleared by reset, but a reset cycle must never write it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

endmodule
